ysyx_24080006_icache_sa: RTL and testbench

Parametrised set-associative instruction cache between the IFU and the AXI read master; successor to the direct-mapped `icache_t` cache. Configurable ways, sets and line size; refills a whole line with one AXI INCR burst, round-robin replacement per set, `fence.i` invalidation, and 32-bit hit/miss counters. Hits return one cycle after acceptance and can be issued back-to-back.

---
 rtl/ysyx_24080006_pkg.sv | 43 ++++
 rtl/ysyx_24080006_icache_way.sv | 51 +++++
 rtl/ysyx_24080006_icache_sa.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_24080006_icache_sa.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the ysyx_24080006 core: cache geometry,
// AXI read-channel bundles and instruction-cache FSM states.
package ysyx_24080006_pkg;

  localparam int IC_M    = 5;
  localparam int IC_N    = 1;
  localparam int IC_WAYS = 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    IC_IDLE,
    IC_LOOKUP,
    IC_AR,
    IC_R,
    IC_RESP
  } ic_state_e;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  // Line record of the direct-mapped configuration.
  typedef struct packed {
    logic                     valid;
    logic [31-IC_M-IC_N:0]    tag;
    logic [(2**IC_M)*8-1:0]   data;
  } icache_t;

endpackage

// File: rtl/ysyx_24080006_icache_way.sv
// One way of the set-associative instruction cache: valid/tag/data held in
// flops, a combinational lookup port and a word-granular refill port.
module ysyx_24080006_icache_way #(
  parameter int  OFFSET_W = 5,
  parameter int  INDEX_W  = 1,
  localparam int LW       = 1 << (OFFSET_W - 2),
  localparam int BEAT_W   = (OFFSET_W > 2) ? OFFSET_W - 2 : 1,
  localparam int SETS     = 1 << INDEX_W,
  localparam int IDX_W    = (INDEX_W > 0) ? INDEX_W : 1,
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  index,
  input  logic [TAG_W-1:0]  tag,
  input  logic [BEAT_W-1:0] rd_word,
  output logic              hit,
  output logic              valid,
  output logic [31:0]       rdata,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic              tag_set,
  input  logic              invalidate
);

  logic [SETS-1:0]  valid_reg;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LW];

  assign valid = valid_reg[index];
  assign hit   = valid_reg[index] && (tag_mem[index] == tag);
  assign rdata = data_mem[index][rd_word];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
    end else if (invalidate) begin
      valid_reg <= '0;
    end else if (tag_set) begin
      valid_reg[index] <= 1'b1;
    end
  end

  // Tag and data contents are qualified by valid, so they need no reset.
  always_ff @(posedge clock) begin
    if (tag_set) tag_mem[index] <= tag;
    if (wr_en)   data_mem[index][wr_word] <= wr_data;
  end

endmodule

// File: rtl/ysyx_24080006_icache_sa.sv
// Set-associative instruction cache between the IFU and an AXI read master:
// whole-line INCR refills, per-set round-robin replacement, fence.i flush.
module ysyx_24080006_icache_sa
  import ysyx_24080006_pkg::*;
#(
  parameter int  WAYS     = IC_WAYS,
  parameter int  OFFSET_W = IC_M,
  parameter int  INDEX_W  = IC_N,
  localparam int LW       = 1 << (OFFSET_W - 2),
  localparam int BEAT_W   = (OFFSET_W > 2) ? OFFSET_W - 2 : 1,
  localparam int SETS     = 1 << INDEX_W,
  localparam int IDX_W    = (INDEX_W > 0) ? INDEX_W : 1,
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W,
  localparam int PTR_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        fence_i,
  output axi_r_m2s_t  axi_r_o,
  input  axi_r_s2m_t  axi_r_i,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam logic [31:0] LINE_MASK = 32'((64'd1 << OFFSET_W) - 64'd1);

  ic_state_e         state;
  logic              alive_reg;
  logic              fence_pend;
  logic              hit_cnted;
  logic [31:0]       addr_reg;
  logic [PTR_W-1:0]  victim_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [PTR_W-1:0]  ptr_reg [SETS];

  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic [BEAT_W-1:0] word;
  logic [WAYS-1:0]   way_hit;
  logic [WAYS-1:0]   way_valid;
  logic [31:0]       way_rdata [WAYS];
  logic              hit;
  logic [31:0]       hit_data;
  logic [PTR_W-1:0]  victim;
  logic              fence_exec;
  logic              lookup_hit;
  logic              accept;
  logic              refill_beat;
  logic              refill_last;

  assign index = (INDEX_W == 0) ? '0 : IDX_W'(addr_reg >> OFFSET_W);
  assign tag   = TAG_W'(addr_reg >> (OFFSET_W + INDEX_W));
  assign word  = (LW == 1) ? '0 : BEAT_W'(addr_reg >> 2);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    ysyx_24080006_icache_way #(
      .OFFSET_W (OFFSET_W),
      .INDEX_W  (INDEX_W)
    ) u_way (
      .clock      (clock),
      .reset_n    (reset_n),
      .index      (index),
      .tag        (tag),
      .rd_word    (word),
      .hit        (way_hit[gi]),
      .valid      (way_valid[gi]),
      .rdata      (way_rdata[gi]),
      .wr_en      (refill_beat && (victim_reg == PTR_W'(gi))),
      .wr_word    (beat_reg),
      .wr_data    (axi_r_i.rdata),
      .tag_set    (refill_last && (victim_reg == PTR_W'(gi))),
      .invalidate (fence_exec)
    );
  end

  // Scan downwards so the lowest-numbered way wins both selections.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    victim   = ptr_reg[index];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) begin
        hit      = 1'b1;
        hit_data = way_rdata[i];
      end
      if (!way_valid[i]) victim = PTR_W'(i);
    end
  end

  assign fence_exec    = (state == IC_IDLE) && fence_pend;
  assign lookup_hit    = (state == IC_LOOKUP) && hit;
  assign ifu_rsp_valid = lookup_hit || (state == IC_RESP);
  assign ifu_rdata     = ifu_rsp_valid ? hit_data : '0;
  // A pending fence also blocks hit chaining so a hit stream cannot starve it.
  assign ifu_req_ready = alive_reg && !fence_pend &&
                         ((state == IC_IDLE) || (lookup_hit && ifu_rsp_ready));
  assign accept        = ifu_req_valid && ifu_req_ready;
  assign refill_beat   = (state == IC_R) && axi_r_i.rvalid;
  assign refill_last   = refill_beat && axi_r_i.rlast;

  always_comb begin
    axi_r_o = '0;
    if (state == IC_AR) begin
      axi_r_o.arvalid = 1'b1;
      axi_r_o.araddr  = addr_reg & ~LINE_MASK;
      axi_r_o.arlen   = 8'(LW - 1);
      axi_r_o.arsize  = AXI_SIZE_4B;
      axi_r_o.arburst = AXI_BURST_INCR;
    end
    axi_r_o.rready = (state == IC_R);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IC_IDLE;
      alive_reg  <= 1'b0;
      fence_pend <= 1'b0;
      hit_cnted  <= 1'b0;
      addr_reg   <= '0;
      victim_reg <= '0;
      beat_reg   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
    end else begin
      alive_reg  <= 1'b1;
      fence_pend <= fence_exec ? fence_i : (fence_pend || fence_i);
      if (fence_exec) begin
        for (int s = 0; s < SETS; s++) ptr_reg[s] <= '0;
      end
      if (accept) addr_reg <= ifu_addr;

      case (state)
        IC_IDLE: begin
          if (accept) begin
            state     <= IC_LOOKUP;
            hit_cnted <= 1'b0;
          end
        end
        IC_LOOKUP: begin
          if (hit) begin
            if (!hit_cnted) hit_cnt <= hit_cnt + 32'd1;
            hit_cnted <= !ifu_rsp_ready;
            if (ifu_rsp_ready && !accept) state <= IC_IDLE;
          end else begin
            miss_cnt   <= miss_cnt + 32'd1;
            victim_reg <= victim;
            state      <= IC_AR;
          end
        end
        IC_AR: begin
          if (axi_r_i.arready) begin
            beat_reg <= '0;
            state    <= IC_R;
          end
        end
        IC_R: begin
          if (refill_beat) begin
            beat_reg <= beat_reg + 1'b1;
            if (axi_r_i.rlast) begin
              ptr_reg[index] <= (WAYS > 1) ? ptr_reg[index] + 1'b1 : '0;
              state          <= IC_RESP;
            end
          end
        end
        IC_RESP: begin
          if (ifu_rsp_ready) state <= IC_IDLE;
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_icache_sa.sv
// Directed bench for the set-associative icache: fills, back-to-back hits,
// round-robin eviction, fence.i, mid-burst reset and response back-pressure.
module tb_ysyx_24080006_icache_sa;
  import ysyx_24080006_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready = 1'b0;
  logic [31:0] ifu_rdata;
  logic        fence_i = 1'b0;
  axi_r_m2s_t  axi_r_o;
  axi_r_s2m_t  axi_r_i = '0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ysyx_24080006_icache_sa dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .fence_i       (fence_i),
    .axi_r_o       (axi_r_o),
    .axi_r_i       (axi_r_i),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  // Backing memory contents seen through the AXI slave.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hCAFE_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  // Miss on address a with a zero-wait AXI slave; optional fence pulse or
  // reset assertion on a given refill beat.
  task automatic miss_fill(input logic [31:0] a, input int fence_beat, input int abort_beat);
    logic [31:0] line;
    line = a & 32'hFFFF_FFE0;
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
    ifu_rsp_ready = 1'b1;
    @(negedge clock);
    chk("miss_req_ready", 32'(ifu_req_ready), 32'd1);
    next_cycle();
    ifu_req_valid = 1'b0;
    @(negedge clock);
    chk("miss_lookup_no_rsp", 32'(ifu_rsp_valid), 32'd0);
    next_cycle();
    axi_r_i.arready = 1'b1;
    @(negedge clock);
    chk("ar_valid", 32'(axi_r_o.arvalid), 32'd1);
    chk("ar_addr", axi_r_o.araddr, line);
    chk("ar_len", 32'(axi_r_o.arlen), 32'd7);
    chk("ar_size", 32'(axi_r_o.arsize), 32'd2);
    chk("ar_burst", 32'(axi_r_o.arburst), 32'd1);
    next_cycle();
    axi_r_i.arready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      axi_r_i.rvalid = 1'b1;
      axi_r_i.rdata  = mem(line + 32'(4 * k));
      axi_r_i.rlast  = (k == 7);
      fence_i        = (k == fence_beat);
      if (k == abort_beat) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(ifu_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        chk("rst_rdata", ifu_rdata, 32'd0);
        chk("rst_rready", 32'(axi_r_o.rready), 32'd0);
        chk("rst_arvalid", 32'(axi_r_o.arvalid), 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        axi_r_i = '0;
        next_cycle();
        reset_n = 1'b1;
        return;
      end
      @(negedge clock);
      chk("r_ready", 32'(axi_r_o.rready), 32'd1);
      next_cycle();
    end
    axi_r_i = '0;
    fence_i = 1'b0;
    @(negedge clock);
    chk("resp_valid", 32'(ifu_rsp_valid), 32'd1);
    chk("resp_rdata", ifu_rdata, mem(a));
    chk("resp_rready_low", 32'(axi_r_o.rready), 32'd0);
    next_cycle();
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
    ifu_rsp_ready = 1'b1;
    @(negedge clock);
    chk("hit_req_ready", 32'(ifu_req_ready), 32'd1);
    next_cycle();
    ifu_req_valid = 1'b0;
    @(negedge clock);
    chk("hit_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
    chk("hit_rdata", ifu_rdata, mem(a));
    next_cycle();
  endtask

  initial begin
    // Reset state.
    next_cycle();
    next_cycle();
    @(negedge clock);
    chk("reset_req_ready", 32'(ifu_req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    chk("reset_arvalid", 32'(axi_r_o.arvalid), 32'd0);
    chk("reset_hit_cnt", hit_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Cold miss: beat 1 of line 0x3000_0000 is returned.
    miss_fill(32'h3000_0004, -1, -1);
    @(negedge clock);
    chk("cold_miss_cnt", miss_cnt, 32'd1);
    chk("cold_hit_cnt", hit_cnt, 32'd0);
    next_cycle();

    // Eight back-to-back hits over the filled line.
    ifu_rsp_ready = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h3000_0000;
    @(negedge clock);
    chk("b2b_first_ready", 32'(ifu_req_ready), 32'd1);
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      ifu_req_valid = (k < 8);
      ifu_addr      = 32'h3000_0000 + 32'(4 * k);
      @(negedge clock);
      chk("b2b_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
      chk("b2b_rdata", ifu_rdata, mem(32'h3000_0000 + 32'(4 * (k - 1))));
      chk("b2b_no_ar", 32'(axi_r_o.arvalid), 32'd0);
      next_cycle();
    end
    @(negedge clock);
    chk("b2b_hit_cnt", hit_cnt, 32'd8);
    chk("b2b_miss_cnt", miss_cnt, 32'd1);
    chk("b2b_idle_no_rsp", 32'(ifu_rsp_valid), 32'd0);
    next_cycle();

    // Three lines in set 0: the third refill evicts the first.
    miss_fill(32'h3000_0040, -1, -1);
    miss_fill(32'h3000_0080, -1, -1);
    fetch_hit(32'h3000_0044);
    miss_fill(32'h3000_0008, -1, -1);
    @(negedge clock);
    chk("rr_miss_cnt", miss_cnt, 32'd4);
    chk("rr_hit_cnt", hit_cnt, 32'd9);
    next_cycle();

    // Response back-pressure for five cycles on a hit.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h3000_0084;
    ifu_rsp_ready = 1'b0;
    @(negedge clock);
    chk("hold_accept", 32'(ifu_req_ready), 32'd1);
    next_cycle();
    ifu_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
      chk("hold_rdata", ifu_rdata, 32'hFAFE_F089);
      chk("hold_req_ready", 32'(ifu_req_ready), 32'd0);
      next_cycle();
    end
    ifu_rsp_ready = 1'b1;
    @(negedge clock);
    chk("hold_release_valid", 32'(ifu_rsp_valid), 32'd1);
    next_cycle();
    @(negedge clock);
    chk("hold_done", 32'(ifu_rsp_valid), 32'd0);
    chk("hold_hit_cnt", hit_cnt, 32'd10);
    next_cycle();

    // fence.i during a burst: refill completes, then the flush cycle.
    miss_fill(32'h3000_0020, 3, -1);
    @(negedge clock);
    chk("fence_idle_not_ready", 32'(ifu_req_ready), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("fence_after_ready", 32'(ifu_req_ready), 32'd1);
    next_cycle();
    miss_fill(32'h3000_0020, -1, -1);
    @(negedge clock);
    chk("fence_miss_cnt", miss_cnt, 32'd6);
    next_cycle();

    // Reset asserted during the third refill beat.
    miss_fill(32'h3000_0100, -1, 2);
    next_cycle();
    miss_fill(32'h3000_0100, -1, -1);
    @(negedge clock);
    chk("post_rst_miss_cnt", miss_cnt, 32'd1);
    chk("post_rst_hit_cnt", hit_cnt, 32'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
